// File: rtl/usb_tx_sched.sv
// usb_tx_sched: arbitrates the PHY TX path between the token/handshake source
// (crc5_t side) and the data source (link layer). It enforces an inter-packet
// gap after every completed, cancelled or aborted packet, and keeps counters
// of completed packets.
//
// Optional feature: define TX_SCHED_WDOG_EN to add a stall watchdog. It aborts
// a granted packet after WDOG_CYCLES consecutive valid-but-not-ready cycles.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   tx_to_req          token/handshake packet pending
//   tx_lt_req          data packet pending
//   ipg_cycles         inter-packet gap length, sampled on gap entry
//   tx_lp_*            monitor taps of the control_t-to-PHY beat interface
//   tx_to_gnt          token/handshake source owns the TX path
//   tx_data_on         data source owns the TX path
//   tx_busy            scheduler not idle
//   wdog_err           one-cycle pulse on watchdog abort (0 without watchdog)
//   pkt_cnt_to/lt      wrapping completed-packet counters
module usb_tx_sched #(
  parameter int unsigned GAP_W       = 8,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_to_req,
  input  logic             tx_lt_req,
  input  logic [GAP_W-1:0] ipg_cycles,
  input  logic             tx_lp_sop,
  input  logic             tx_lp_eop,
  input  logic             tx_lp_valid,
  input  logic             tx_lp_ready,
  input  logic             tx_lp_cancle,
  output logic             tx_to_gnt,
  output logic             tx_data_on,
  output logic             tx_busy,
  output logic             wdog_err,
  output logic [15:0]      pkt_cnt_to,
  output logic [15:0]      pkt_cnt_lt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GNT_TO = 2'd1,
    S_GNT_LT = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic             r_sop_seen, w_sop_seen_nxt;
  logic [15:0]      r_pkt_cnt_to, w_pkt_cnt_to_nxt;
  logic [15:0]      r_pkt_cnt_lt, w_pkt_cnt_lt_nxt;
  logic             r_to_gnt, r_data_on, r_busy;
  logic             w_beat, w_sop_beat, w_wdog_hit;

  assign w_beat     = tx_lp_valid & tx_lp_ready;
  assign w_sop_beat = w_beat & tx_lp_sop;

`ifdef TX_SCHED_WDOG_EN
  // Counter holds 0..WDOG_CYCLES-1; the hit fires on the WDOG_CYCLES-th stall.
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;
  logic              w_stall;

  assign w_stall    = ((r_state == S_GNT_TO) || (r_state == S_GNT_LT)) &
                      tx_lp_valid & ~tx_lp_ready;
  assign w_wdog_hit = w_stall && (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign wdog_err   = r_wdog_err;

  // Consecutive-stall counter; any non-stall cycle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_err <= w_wdog_hit;
      if (w_stall && !w_wdog_hit) r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
      else                        r_wdog_cnt <= '0;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  // Next-state, gap counter, sop tracking and packet counters.
  always_comb begin
    w_state_nxt      = r_state;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_sop_seen_nxt   = r_sop_seen;
    w_pkt_cnt_to_nxt = r_pkt_cnt_to;
    w_pkt_cnt_lt_nxt = r_pkt_cnt_lt;

    case (r_state)
      S_IDLE: begin
        if (tx_to_req)      w_state_nxt = S_GNT_TO;
        else if (tx_lt_req) w_state_nxt = S_GNT_LT;
      end
      S_GNT_TO: begin
        if (w_sop_beat) w_sop_seen_nxt = 1'b1;
        if (w_beat && tx_lp_eop) begin
          w_state_nxt      = S_GAP;
          w_pkt_cnt_to_nxt = r_pkt_cnt_to + 16'd1;
        end else if (w_wdog_hit) begin
          w_state_nxt = S_GAP;
        end else if (!tx_to_req && !r_sop_seen && !w_sop_beat) begin
          // Request withdrawn before the packet started: no gap needed.
          w_state_nxt = S_IDLE;
        end
      end
      S_GNT_LT: begin
        if (w_sop_beat) w_sop_seen_nxt = 1'b1;
        if (w_beat && tx_lp_cancle) begin
          // Cancel takes precedence over a coincident eop and is not counted.
          w_state_nxt = S_GAP;
        end else if (w_beat && tx_lp_eop) begin
          w_state_nxt      = S_GAP;
          w_pkt_cnt_lt_nxt = r_pkt_cnt_lt + 16'd1;
        end else if (w_wdog_hit) begin
          w_state_nxt = S_GAP;
        end else if (!tx_lt_req && !r_sop_seen && !w_sop_beat) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        // A loaded value of 0 ends the gap after one cycle, same as 1.
        if (r_gap_cnt <= GAP_W'(1)) w_state_nxt   = S_IDLE;
        else                        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if ((w_state_nxt == S_GAP) && (r_state != S_GAP)) w_gap_cnt_nxt = ipg_cycles;
    if ((w_state_nxt == S_GAP) || (w_state_nxt == S_IDLE)) w_sop_seen_nxt = 1'b0;
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_sop_seen   <= 1'b0;
      r_pkt_cnt_to <= '0;
      r_pkt_cnt_lt <= '0;
      r_to_gnt     <= 1'b0;
      r_data_on    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_sop_seen   <= w_sop_seen_nxt;
      r_pkt_cnt_to <= w_pkt_cnt_to_nxt;
      r_pkt_cnt_lt <= w_pkt_cnt_lt_nxt;
      r_to_gnt     <= (w_state_nxt == S_GNT_TO);
      r_data_on    <= (w_state_nxt == S_GNT_LT);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign tx_to_gnt  = r_to_gnt;
  assign tx_data_on = r_data_on;
  assign tx_busy    = r_busy;
  assign pkt_cnt_to = r_pkt_cnt_to;
  assign pkt_cnt_lt = r_pkt_cnt_lt;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed self-checking bench for usb_tx_sched. Clock period 20 ns, rising
// edges at 10 + 20k ns. Inputs are driven and outputs sampled 1 ns after a
// rising edge.
module tb_usb_tx_sched;

  logic        clk;
  logic        rst_n;
  logic        tx_to_req, tx_lt_req;
  logic [7:0]  ipg_cycles;
  logic        tx_lp_sop, tx_lp_eop, tx_lp_valid, tx_lp_ready, tx_lp_cancle;
  logic        tx_to_gnt, tx_data_on, tx_busy, wdog_err;
  logic [15:0] pkt_cnt_to, pkt_cnt_lt;

  int errors = 0;
  int checks = 0;

  usb_tx_sched #(.GAP_W(8), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_to_req(tx_to_req), .tx_lt_req(tx_lt_req), .ipg_cycles(ipg_cycles),
    .tx_lp_sop(tx_lp_sop), .tx_lp_eop(tx_lp_eop), .tx_lp_valid(tx_lp_valid),
    .tx_lp_ready(tx_lp_ready), .tx_lp_cancle(tx_lp_cancle),
    .tx_to_gnt(tx_to_gnt), .tx_data_on(tx_data_on), .tx_busy(tx_busy),
    .wdog_err(wdog_err), .pkt_cnt_to(pkt_cnt_to), .pkt_cnt_lt(pkt_cnt_lt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beat();
    tx_lp_sop = 0; tx_lp_eop = 0; tx_lp_valid = 0; tx_lp_ready = 0; tx_lp_cancle = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; tx_to_req = 1; tx_lt_req = 0; ipg_cycles = 8'd3;
    clear_beat();
    #51;
    checks++;
    if ({tx_to_gnt, tx_data_on, tx_busy, wdog_err, pkt_cnt_to, pkt_cnt_lt} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b on=%b busy=%b werr=%b cto=%h clt=%h, want all 0",
               tx_to_gnt, tx_data_on, tx_busy, wdog_err, pkt_cnt_to, pkt_cnt_lt);
    end
    tx_to_req = 0;
    step(); step(); step();
    rst_n = 1;
  endtask

  // Token packet: request driven at 130 ns, eop beat driven at 830 ns.
  task automatic test_to_packet();
    logic held;
    int   gap_len;
    step();                                   // 131 ns
    checks++;
    if (tx_to_gnt !== 1'b0) begin errors++; $display("FAIL to_gnt_before_req: got %b want 0", tx_to_gnt); end
    tx_to_req = 1; ipg_cycles = 8'd4;
    step();                                   // 151 ns
    checks++;
    if ({tx_to_gnt, tx_data_on, tx_busy} !== 3'b101) begin
      errors++; $display("FAIL to_gnt_rise: got gnt/on/busy=%b want 101", {tx_to_gnt, tx_data_on, tx_busy});
    end
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1;
    held = 1'b1;
    for (int i = 0; i < 34; i++) begin       // through 831 ns
      step();
      clear_beat();
      held &= tx_to_gnt;
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL to_gnt_held: got %b want 1", held); end
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_eop = 1; tx_to_req = 0;
    step();                                   // 851 ns, GAP entered
    clear_beat();
    ipg_cycles = 8'd9;                        // must not affect the running gap
    checks++;
    if ({tx_to_gnt, tx_busy, pkt_cnt_to} !== {1'b0, 1'b1, 16'd1}) begin
      errors++; $display("FAIL to_eop: got gnt=%b busy=%b cnt_to=%0d want 0 1 1", tx_to_gnt, tx_busy, pkt_cnt_to);
    end
    gap_len = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_busy) gap_len++;
      else break;
    end
    checks++;
    if (gap_len !== 4) begin errors++; $display("FAIL to_gap_len: got %0d want 4", gap_len); end
  endtask

  task automatic test_priority();
    tx_to_req = 1; tx_lt_req = 1; ipg_cycles = 8'd2;
    step();
    checks++;
    if ({tx_to_gnt, tx_data_on} !== 2'b10) begin
      errors++; $display("FAIL prio_to_first: got gnt/on=%b want 10", {tx_to_gnt, tx_data_on});
    end
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1; tx_lp_eop = 1; tx_to_req = 0;
    step();
    clear_beat();
    checks++;
    if ({tx_to_gnt, tx_data_on, tx_busy, pkt_cnt_to} !== {3'b001, 16'd2}) begin
      errors++; $display("FAIL prio_gap_entry: got gnt=%b on=%b busy=%b cnt_to=%0d want 0 0 1 2",
                         tx_to_gnt, tx_data_on, tx_busy, pkt_cnt_to);
    end
    step();
    checks++;
    if ({tx_data_on, tx_busy} !== 2'b01) begin
      errors++; $display("FAIL prio_gap_hold: got on/busy=%b want 01", {tx_data_on, tx_busy});
    end
    step();
    checks++;
    if ({tx_data_on, tx_busy} !== 2'b00) begin
      errors++; $display("FAIL prio_idle: got on/busy=%b want 00", {tx_data_on, tx_busy});
    end
    step();
    checks++;
    if ({tx_to_gnt, tx_data_on} !== 2'b01) begin
      errors++; $display("FAIL prio_lt_after_gap: got gnt/on=%b want 01", {tx_to_gnt, tx_data_on});
    end
  endtask

  // Continues in GNT_LT: 9 beats, ready high one cycle in three.
  task automatic test_data_pkt();
    int   beats;
    logic held, cnt_ok;
    beats = 0; held = 1'b1; cnt_ok = 1'b1; ipg_cycles = 8'd1;
    for (int c = 0; c < 60 && beats < 9; c++) begin
      tx_lp_valid = 1;
      tx_lp_ready = ((c % 3) == 2);
      tx_lp_sop   = (beats == 0);
      tx_lp_eop   = (beats == 8);
      step();
      if (tx_lp_ready) beats++;
      if (beats < 9) begin
        held   &= tx_data_on;
        cnt_ok &= (pkt_cnt_lt == 16'd0);
      end
    end
    clear_beat(); tx_lt_req = 0;
    checks++;
    if ({held, cnt_ok} !== 2'b11 || beats !== 9) begin
      errors++; $display("FAIL data_hold: got held=%b cnt_ok=%b beats=%0d want 1 1 9", held, cnt_ok, beats);
    end
    checks++;
    if ({tx_data_on, tx_busy, pkt_cnt_lt} !== {2'b01, 16'd1}) begin
      errors++; $display("FAIL data_eop: got on=%b busy=%b cnt_lt=%0d want 0 1 1", tx_data_on, tx_busy, pkt_cnt_lt);
    end
    step();
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL data_gap1: got busy=%b want 0", tx_busy); end
  endtask

  task automatic test_cancel();
    tx_lt_req = 1; ipg_cycles = 8'd0;
    step();
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1;
    step();
    clear_beat();
    checks++;
    if (tx_data_on !== 1'b1) begin errors++; $display("FAIL cancel_pre: got on=%b want 1", tx_data_on); end
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_cancle = 1; tx_lp_eop = 1; tx_lt_req = 0;
    step();
    clear_beat();
    checks++;
    if ({tx_data_on, tx_busy, pkt_cnt_lt} !== {2'b01, 16'd1}) begin
      errors++; $display("FAIL cancel_gap: got on=%b busy=%b cnt_lt=%0d want 0 1 1", tx_data_on, tx_busy, pkt_cnt_lt);
    end
    step();
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL cancel_ipg0: got busy=%b want 0", tx_busy); end
  endtask

  task automatic test_req_drop();
    logic held;
    tx_lt_req = 1;
    step();
    tx_lt_req = 0;
    step();
    checks++;
    if ({tx_data_on, tx_busy} !== 2'b00) begin
      errors++; $display("FAIL drop_nogap: got on/busy=%b want 00", {tx_data_on, tx_busy});
    end
    tx_to_req = 1;
    step();
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1; tx_to_req = 0;
    step();
    clear_beat();
    held = tx_to_gnt;
    for (int i = 0; i < 3; i++) begin step(); held &= tx_to_gnt; end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL drop_after_sop: got held=%b want 1", held); end
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_eop = 1;
    step();
    clear_beat();
    checks++;
    if ({tx_to_gnt, tx_busy, pkt_cnt_to} !== {2'b01, 16'd3}) begin
      errors++; $display("FAIL drop_eop: got gnt=%b busy=%b cnt_to=%0d want 0 1 3", tx_to_gnt, tx_busy, pkt_cnt_to);
    end
    step();
  endtask

  task automatic test_watchdog();
    logic held, werr_quiet;
    held = 1'b1; werr_quiet = 1'b1;
    tx_lt_req = 1; ipg_cycles = 8'd0;
    step();
    tx_lp_valid = 1; tx_lp_ready = 0; tx_lp_sop = 1;
`ifdef TX_SCHED_WDOG_EN
    for (int i = 0; i < 7; i++) begin
      step(); held &= tx_data_on; werr_quiet &= ~wdog_err;
    end
    checks++;
    if ({held, werr_quiet} !== 2'b11) begin
      errors++; $display("FAIL wdog_pre: got held=%b quiet=%b want 1 1", held, werr_quiet);
    end
    step();
    clear_beat(); tx_lt_req = 0;
    checks++;
    if ({tx_data_on, wdog_err, tx_busy, pkt_cnt_lt} !== {3'b011, 16'd1}) begin
      errors++; $display("FAIL wdog_abort: got on=%b werr=%b busy=%b cnt_lt=%0d want 0 1 1 1",
                         tx_data_on, wdog_err, tx_busy, pkt_cnt_lt);
    end
    step();
    checks++;
    if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_pulse_len: got %b want 0", wdog_err); end
`else
    for (int i = 0; i < 20; i++) begin
      step(); held &= tx_data_on; werr_quiet &= ~wdog_err;
    end
    checks++;
    if ({held, werr_quiet} !== 2'b11) begin
      errors++; $display("FAIL stall_held: got held=%b quiet=%b want 1 1", held, werr_quiet);
    end
    tx_lp_ready = 1; tx_lp_eop = 1; tx_lt_req = 0;
    step();
    clear_beat();
    checks++;
    if ({tx_data_on, pkt_cnt_lt} !== {1'b0, 16'd2}) begin
      errors++; $display("FAIL stall_release: got on=%b cnt_lt=%0d want 0 2", tx_data_on, pkt_cnt_lt);
    end
`endif
    step();
  endtask

  task automatic test_wrap_reset();
    force dut.r_pkt_cnt_to = 16'hFFFF;
    step(); step();
    release dut.r_pkt_cnt_to;
    tx_to_req = 1;
    step();
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1;
    step();
    clear_beat();
    checks++;
    if ({tx_to_gnt, pkt_cnt_to} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL preload_mid_pkt: got gnt=%b cnt_to=%h want 1 ffff", tx_to_gnt, pkt_cnt_to);
    end
    #5 rst_n = 0;
    #1;
    checks++;
    if ({tx_to_gnt, tx_data_on, tx_busy, wdog_err, pkt_cnt_to, pkt_cnt_lt} !== 36'd0) begin
      errors++; $display("FAIL reset_mid_pkt: got gnt=%b on=%b busy=%b werr=%b cto=%h clt=%h want all 0",
                         tx_to_gnt, tx_data_on, tx_busy, wdog_err, pkt_cnt_to, pkt_cnt_lt);
    end
    tx_to_req = 0;
    step();
    rst_n = 1;
    step();
    checks++;
    if ({tx_to_gnt, tx_busy, pkt_cnt_to} !== 18'd0) begin
      errors++; $display("FAIL reset_release: got gnt=%b busy=%b cnt_to=%h want 0 0 0", tx_to_gnt, tx_busy, pkt_cnt_to);
    end
    force dut.r_pkt_cnt_to = 16'hFFFF;
    step(); step();
    release dut.r_pkt_cnt_to;
    tx_to_req = 1;
    step();
    tx_lp_valid = 1; tx_lp_ready = 1; tx_lp_sop = 1; tx_lp_eop = 1; tx_to_req = 0;
    step();
    clear_beat();
    checks++;
    if ({tx_to_gnt, pkt_cnt_to} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL cnt_wrap: got gnt=%b cnt_to=%h want 0 0000", tx_to_gnt, pkt_cnt_to);
    end
  endtask

  initial begin
    test_reset();
    test_to_packet();
    test_priority();
    test_data_pkt();
    test_cancel();
    test_req_drop();
    test_watchdog();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
